// File: rtl/timer_countdown.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : timer_countdown                                            |
// | Description : Consumer end of the keypad timer-entry interface. Captures |
// |               the M:TS BCD digits while loadn is low, then counts down   |
// |               once per 1 Hz tick while RUNNING. Drives the cook-enable   |
// |               output and a completion pulse for the alarm/controller.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Optional feature macro: TIMER_CLAMP_EN                                   |
// |   defined   : on load, minute/second digits > 9 saturate to 9 and the    |
// |               tens-of-seconds digit saturates to SEC_TENS_MAX.           |
// |   undefined : digits are loaded raw.                                     |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   1  system clock (100 Hz domain)                      |
// |   rst          in   1  synchronous active-high reset                     |
// |   loadn        in   1  active-low load strobe for the digit inputs       |
// |   min_in       in   4  units-of-minutes digit                            |
// |   tens_sec_in  in   4  tens-of-seconds digit                             |
// |   sec_in       in   4  units-of-seconds digit                            |
// |   start        in   1  level: begin/resume countdown                     |
// |   stop         in   1  level: pause                                      |
// |   clear        in   1  level: abort, zero count, return to IDLE          |
// |   tick_in      in   1  asynchronous 1 Hz square wave                     |
// |   min_out      out  4  current units-of-minutes                          |
// |   tens_sec_out out  4  current tens-of-seconds                           |
// |   sec_out      out  4  current units-of-seconds                          |
// |   running      out  1  high only in RUNNING (cook enable)                |
// |   zero         out  1  high when count == 0:00                           |
// |   done_pulse   out  1  high DONE_CYCLES cycles after reaching 0:00       |
// |   state_out    out  3  IDLE=0 LOADED=1 RUNNING=2 PAUSED=3 DONE=4         |
// +--------------------------------------------------------------------------+

module timer_countdown #(
  parameter int SEC_TENS_MAX  = 5,
  parameter int SEC_UNITS_MAX = 9,
  parameter int DONE_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       loadn,
  input  logic [3:0] min_in,
  input  logic [3:0] tens_sec_in,
  input  logic [3:0] sec_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       tick_in,
  output logic [3:0] min_out,
  output logic [3:0] tens_sec_out,
  output logic [3:0] sec_out,
  output logic       running,
  output logic       zero,
  output logic       done_pulse,
  output logic [2:0] state_out
);

  // Remaining-cycles counter for done_pulse; at least one bit wide even
  // when DONE_CYCLES == 1 (the counter then simply stays at zero).
  localparam int CNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  localparam logic [3:0]       c_tens_max  = 4'(SEC_TENS_MAX);
  localparam logic [3:0]       c_units_max = 4'(SEC_UNITS_MAX);
  localparam logic [3:0]       c_digit_max = 4'd9;
  localparam logic [CNT_W-1:0] c_done_rem  = CNT_W'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t           state_q;
  logic [3:0]       min_q;
  logic [3:0]       tens_q;
  logic [3:0]       sec_q;
  logic             tick_s1_q;
  logic             tick_s2_q;
  logic             tick_s3_q;
  logic             done_pulse_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic             tick_d;
  logic [3:0]       load_min_d;
  logic [3:0]       load_tens_d;
  logic [3:0]       load_sec_d;
  logic [3:0]       dec_min_d;
  logic [3:0]       dec_tens_d;
  logic [3:0]       dec_sec_d;
  logic             count_nz;
  logic             load_nz;
  logic             dec_zero;

  // One-cycle strobe on the synchronised rising edge of tick_in.
  assign tick_d = tick_s2_q & ~tick_s3_q;

`ifdef TIMER_CLAMP_EN
  assign load_min_d  = (min_in      > c_digit_max) ? c_digit_max : min_in;
  assign load_tens_d = (tens_sec_in > c_tens_max)  ? c_tens_max  : tens_sec_in;
  assign load_sec_d  = (sec_in      > c_digit_max) ? c_digit_max : sec_in;
`else
  assign load_min_d  = min_in;
  assign load_tens_d = tens_sec_in;
  assign load_sec_d  = sec_in;
`endif

  assign count_nz = (min_q != 4'd0) || (tens_q != 4'd0) || (sec_q != 4'd0);
  assign load_nz  = (load_min_d != 4'd0) || (load_tens_d != 4'd0) || (load_sec_d != 4'd0);

  // BCD borrow chain. Any nonzero digit counts as nonzero, so raw
  // out-of-range digits simply count down through their own values.
  always_comb begin
    dec_min_d  = min_q;
    dec_tens_d = tens_q;
    dec_sec_d  = sec_q;
    if (sec_q != 4'd0) begin
      dec_sec_d = sec_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_tens_d = tens_q - 4'd1;
      dec_sec_d  = c_units_max;
    end else begin
      dec_min_d  = min_q - 4'd1;
      dec_tens_d = c_tens_max;
      dec_sec_d  = c_units_max;
    end
  end

  assign dec_zero = (dec_min_d == 4'd0) && (dec_tens_d == 4'd0) && (dec_sec_d == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      min_q        <= 4'd0;
      tens_q       <= 4'd0;
      sec_q        <= 4'd0;
      tick_s1_q    <= 1'b0;
      tick_s2_q    <= 1'b0;
      tick_s3_q    <= 1'b0;
      done_pulse_q <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      tick_s1_q <= tick_in;
      tick_s2_q <= tick_s1_q;
      tick_s3_q <= tick_s2_q;

      // Age an active completion pulse; a new completion below overrides.
      if (done_pulse_q) begin
        if (done_cnt_q == '0) begin
          done_pulse_q <= 1'b0;
        end else begin
          done_cnt_q <= done_cnt_q - CNT_W'(1);
        end
      end

      // Event priority: clear > load > stop > start > tick.
      if (clear) begin
        min_q        <= 4'd0;
        tens_q       <= 4'd0;
        sec_q        <= 4'd0;
        state_q      <= ST_IDLE;
        done_pulse_q <= 1'b0;
        done_cnt_q   <= '0;
      end else if (!loadn && (state_q != ST_RUNNING)) begin
        min_q   <= load_min_d;
        tens_q  <= load_tens_d;
        sec_q   <= load_sec_d;
        state_q <= load_nz ? ST_LOADED : ST_IDLE;
      end else if (stop) begin
        // Stop also masks start and any coincident tick.
        if (state_q == ST_RUNNING) begin
          state_q <= ST_PAUSED;
        end
      end else if (start && count_nz &&
                   ((state_q == ST_LOADED) || (state_q == ST_PAUSED))) begin
        state_q <= ST_RUNNING;
      end else if (tick_d && (state_q == ST_RUNNING)) begin
        min_q  <= dec_min_d;
        tens_q <= dec_tens_d;
        sec_q  <= dec_sec_d;
        if (dec_zero) begin
          state_q      <= ST_DONE;
          done_pulse_q <= 1'b1;
          done_cnt_q   <= c_done_rem;
        end
      end
    end
  end

  assign min_out      = min_q;
  assign tens_sec_out = tens_q;
  assign sec_out      = sec_q;
  assign running      = (state_q == ST_RUNNING);
  assign zero         = ~count_nz;
  assign done_pulse   = done_pulse_q;
  assign state_out    = state_q;

endmodule

`default_nettype wire
